// File: rtl/mem_access_seq.sv
`timescale 1ns/1ps
// Multi-byte bus access sequencer: transfers 1..3 bytes little-endian
// between a 24-bit word and an 8-bit bus, with linear, bank or page
// address wrapping. Everything advances only on cpu_en cycles.
module mem_access_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  len,
  input  logic [1:0]  wrap_mode,
  input  logic [23:0] addr_in,
  input  logic [23:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [23:0] rdata_out,
  output logic [23:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ready,
  output logic        addr_inc,
  output logic        page_wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [1:0]  len_l;
  logic [1:0]  wrap_l;
  logic        rw_l;
  logic [23:0] wdata_l;
  logic        accept, advance, last, dir_nx;
  logic [23:0] addr_nx;
  logic [7:0]  wbyte_nx;

  // Handshake qualifiers, next address and next write byte
  always_comb begin
    accept   = cpu_en & req & (state == IDLE);
    advance  = cpu_en & bus_ready & (state == ACCESS);
    last     = (idx == (len_l - 2'd1));
    addr_inc = advance & ~last;
    idx_nx   = idx + 2'd1;
    dir_nx   = accept ? rw : rw_l;
    case (wrap_l)
      2'd1:    addr_nx = {bus_addr[23:16], bus_addr[15:0] + 16'd1};
      2'd2:    addr_nx = {bus_addr[23:8], bus_addr[7:0] + 8'd1};
      default: addr_nx = bus_addr + 24'd1;
    endcase
    case (idx_nx)
      2'd1:    wbyte_nx = wdata_l[15:8];
      2'd2:    wbyte_nx = wdata_l[23:16];
      default: wbyte_nx = wdata_l[7:0];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  if (advance && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, frozen while cpu_en is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    state <= IDLE;
    else if (cpu_en) state <= state_nx;
  end

  // Registered outputs and operand latches; strobes/busy follow the next
  // state so they line up with ACCESS, while done trails DONE by one
  // enabled cycle to give the N+1 edge completion latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_out <= '0;
      page_wrap <= 1'b0;
      idx       <= '0;
      len_l     <= 2'd1;
      wrap_l    <= '0;
      rw_l      <= 1'b0;
      wdata_l   <= '0;
    end else if (cpu_en) begin
      busy   <= (state_nx != IDLE);
      done   <= (state == DONE);
      bus_rd <= (state_nx == ACCESS) &  dir_nx;
      bus_wr <= (state_nx == ACCESS) & ~dir_nx;
      if (accept) begin
        rw_l      <= rw;
        len_l     <= (len == 2'd0) ? 2'd1 : len;
        wrap_l    <= (wrap_mode == 2'd3) ? 2'd0 : wrap_mode;
        wdata_l   <= wdata_in;
        idx       <= '0;
        rdata_out <= '0;
        bus_addr  <= addr_in;
        bus_wdata <= wdata_in[7:0];
        page_wrap <= (wrap_mode == 2'd2);
      end else if (advance) begin
        if (rw_l) begin
          case (idx)
            2'd0:    rdata_out[7:0]   <= bus_rdata;
            2'd1:    rdata_out[15:8]  <= bus_rdata;
            default: rdata_out[23:16] <= bus_rdata;
          endcase
        end
        if (!last) begin
          idx       <= idx_nx;
          bus_addr  <= addr_nx;
          bus_wdata <= wbyte_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_access_seq: each transfer pushes its expected
// bus beats and final read word; a negedge monitor pops and compares.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_en = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  len = '0;
  logic [1:0]  wrap_mode = '0;
  logic [23:0] addr_in = '0;
  logic [23:0] wdata_in = '0;
  logic [7:0]  bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        busy, done, bus_rd, bus_wr, addr_inc, page_wrap;
  logic [23:0] rdata_out, bus_addr;
  logic [7:0]  bus_wdata;

  int total = 0;
  int bad = 0;
  int excl_err = 0;

  typedef struct packed {
    logic        rd;
    logic [23:0] addr;
    logic [7:0]  wd;
    logic        inc;
    logic        pw;
  } beat_t;

  beat_t       beat_q[$];
  logic [23:0] done_q[$];

  always #5 clk = ~clk;

  mem_access_seq dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .req(req), .rw(rw),
    .len(len), .wrap_mode(wrap_mode), .addr_in(addr_in), .wdata_in(wdata_in),
    .busy(busy), .done(done), .rdata_out(rdata_out), .bus_addr(bus_addr),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .addr_inc(addr_inc),
    .page_wrap(page_wrap)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a beat completes on an enabled cycle with ready and a strobe;
  // a completion is counted on the enabled cycle where done is seen.
  always @(negedge clk) begin
    beat_t e;
    if (reset_n) begin
      if (bus_rd && bus_wr) excl_err++;
      if (cpu_en && bus_ready && (bus_rd || bus_wr)) begin
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got addr %0h expected none", bus_addr);
        end else begin
          e = beat_q.pop_front();
          chk("beat_strobes", {30'd0, bus_rd, bus_wr}, {30'd0, e.rd, ~e.rd});
          chk("beat_addr", {8'd0, bus_addr}, {8'd0, e.addr});
          if (!e.rd) chk("beat_wdata", {24'd0, bus_wdata}, {24'd0, e.wd});
          chk("beat_addr_inc", {31'd0, addr_inc}, {31'd0, e.inc});
          chk("beat_page_wrap", {31'd0, page_wrap}, {31'd0, e.pw});
        end
      end
      if (done && cpu_en) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got rdata %0h expected no done", rdata_out);
        end else begin
          chk("done_rdata", {8'd0, rdata_out}, {8'd0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic xfer(input string nm, input logic r, input logic [1:0] l,
                      input logic [1:0] m, input logic [23:0] a,
                      input logic [23:0] wd, input logic [23:0] rb,
                      input int waits, input bit tog, input int n,
                      input logic [23:0] a0, input logic [23:0] a1,
                      input logic [23:0] a2, input logic [23:0] er,
                      input logic pw);
    logic [23:0] ea [3];
    int wl, beat, done_cyc, scnt;
    bit tmo;
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    for (int k = 0; k < n; k++)
      beat_q.push_back('{rd: r, addr: ea[k], wd: wd[8*k +: 8], inc: (k < n-1), pw: pw});
    done_q.push_back(er);
    @(posedge clk); #1;
    cpu_en = 1'b1; req = 1'b1; rw = r; len = l; wrap_mode = m;
    addr_in = a; wdata_in = wd; bus_ready = 1'b1; bus_rdata = 8'hEE;
    @(posedge clk); #1;
    // Scramble inputs so any use of unlatched operands shows up
    req = 1'b0; addr_in = 24'hA5A5A5; wdata_in = 24'h5A5A5A;
    rw = ~r; len = ~l; wrap_mode = ~m;
    wl = waits; beat = 0; done_cyc = -1; scnt = 0; tmo = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      cpu_en = (!tog || done_cyc >= 0) ? 1'b1 : (cyc % 2 == 0);
      req = (cyc == 2);
      bus_rdata = 8'hEE;
      bus_ready = 1'b1;
      if ((bus_rd || bus_wr) && cpu_en) begin
        if (wl > 0) begin
          bus_ready = 1'b0;
          wl--;
        end else begin
          bus_rdata = rb[8*beat +: 8];
          beat++;
        end
      end
      @(negedge clk);
      if (cyc == 1) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      if (bus_rd || bus_wr) scnt++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (tmo) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done within 60 cycles", nm);
    end else begin
      chk({nm, "_latency"}, done_cyc - 1, tog ? 2*(n+1) : n+1+waits);
      chk({nm, "_strobe_cycles"}, scnt, tog ? 2*n : n+waits);
      chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_queues"}, beat_q.size() + done_q.size(), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, bus_rd, bus_wr, addr_inc, page_wrap}, 32'd0);
    chk("reset_addr", {8'd0, bus_addr}, 32'd0);
    chk("reset_data", {bus_wdata, rdata_out}, 32'd0);
    reset_n = 1'b1;

    xfer("rd_lin",    1'b1, 2'd2, 2'd0, 24'h12FFFF, 24'h000000, 24'h00ABCD, 0, 1'b0, 2,
         24'h12FFFF, 24'h130000, 24'h000000, 24'h00ABCD, 1'b0);
    xfer("rd_page",   1'b1, 2'd3, 2'd2, 24'h7E00FE, 24'h000000, 24'h563412, 0, 1'b0, 3,
         24'h7E00FE, 24'h7E00FF, 24'h7E0000, 24'h563412, 1'b1);
    xfer("wr_bank",   1'b0, 2'd2, 2'd1, 24'h01FFFF, 24'h003412, 24'h000000, 0, 1'b0, 2,
         24'h01FFFF, 24'h010000, 24'h000000, 24'h000000, 1'b0);
    xfer("rd_wait",   1'b1, 2'd1, 2'd0, 24'h000100, 24'h000000, 24'h00005A, 3, 1'b0, 1,
         24'h000100, 24'h000000, 24'h000000, 24'h00005A, 1'b0);
    xfer("rd_toggle", 1'b1, 2'd3, 2'd0, 24'hFFFFFE, 24'h000000, 24'hC3B2A1, 0, 1'b1, 3,
         24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'hC3B2A1, 1'b0);
    xfer("wr_len0",   1'b0, 2'd0, 2'd3, 24'h00FFFF, 24'h0000EE, 24'h000000, 0, 1'b0, 1,
         24'h00FFFF, 24'h000000, 24'h000000, 24'h000000, 1'b0);
    xfer("rd_mode3",  1'b1, 2'd2, 2'd3, 24'h00FFFF, 24'h000000, 24'h002211, 0, 1'b0, 2,
         24'h00FFFF, 24'h010000, 24'h000000, 24'h002211, 1'b0);

    // Abort a 3-byte read during byte 1: only byte 0 may complete, no done
    beat_q.push_back('{rd: 1'b1, addr: 24'h000010, wd: 8'h00, inc: 1'b1, pw: 1'b0});
    @(posedge clk); #1;
    cpu_en = 1'b1; req = 1'b1; rw = 1'b1; len = 2'd3; wrap_mode = 2'd0;
    addr_in = 24'h000010; bus_ready = 1'b1; bus_rdata = 8'h77;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort_pre_strobe", {31'd0, bus_rd}, 32'd1);
    chk("abort_pre_addr", {8'd0, bus_addr}, 32'h000011);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ctrl", {26'd0, busy, done, bus_rd, bus_wr, addr_inc, page_wrap}, 32'd0);
    chk("abort_addr", {8'd0, bus_addr}, 32'd0);
    chk("abort_data", {bus_wdata, rdata_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_queues", beat_q.size() + done_q.size(), 32'd0);

    xfer("rd_after_rst", 1'b1, 2'd3, 2'd1, 24'h00FFFE, 24'h000000, 24'h332211, 0, 1'b0, 3,
         24'h00FFFE, 24'h00FFFF, 24'h000000, 24'h332211, 1'b0);

    repeat (3) @(posedge clk);
    chk("strobe_exclusive", excl_err, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule
